// File: rtl/rr_arbiter_n_pkg.sv
// Shared types, default sizes and width helper for the round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rr_state_t;

  localparam int RR_DEF_N        = 4;
  localparam int RR_DEF_MAX_HOLD = 4;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int rr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_n_if
  import rr_arb_pkg::*;
#(
    parameter int N = RR_DEF_N
) ();

    // Handshake: req[i] is a level request from requester i. grant is
    // registered and one-hot-or-zero; grant_valid = |grant, and grant_id
    // is the index of the set bit (0 when grant_valid = 0). There is no
    // ready: a grant bit means requester i owns the resource that cycle.
    logic [N-1:0]       req;
    logic [N-1:0]       grant;
    logic               grant_valid;
    logic [rr_w(N)-1:0] grant_id;

    modport master (output req, input grant, input grant_valid, input grant_id);
    modport slave  (input req, output grant, output grant_valid, output grant_id);

endinterface

// File: rtl/rr_arbiter_n_pick.sv
// Combinational round-robin search: first set req bit from ptr+1 upward, wrapping.
module rr_pick
  import rr_arb_pkg::*;
#(
    parameter int N = RR_DEF_N,
    localparam int W = rr_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        // i = N lands back on ptr itself, so a lone holder can be re-granted.
        for (int i = 1; i <= N; i++) begin
            j = W'((int'(ptr) + i) % N);
            if (!found && req[j]) begin
                found     = 1'b1;
                idx       = j;
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant.
// Optional RR_ARB_HOLD_EN lets a holder keep the grant for up to MAX_HOLD cycles.
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
    parameter int N        = RR_DEF_N,
    parameter int MAX_HOLD = RR_DEF_MAX_HOLD,
    localparam int W = rr_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_n_if.slave bus,
    output rr_state_t     state
);

    if (N < 2 || N > 32) begin : g_bad_n
        $error("rr_arbiter_n: N=%0d outside 2..32", N);
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("rr_arbiter_n: MAX_HOLD=%0d must be >= 1", MAX_HOLD);
    end

    rr_state_t    state_q, nxt_state;
    logic [N-1:0] grant_q, nxt_grant;
    logic [W-1:0] id_q, nxt_id;
    logic [W-1:0] ptr_q, nxt_ptr;
    logic         valid_q;
    logic         keep;

    logic [N-1:0] pick_onehot;
    logic [W-1:0] pick_idx;
    logic         pick_found;

    rr_pick #(.N(N)) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

`ifdef RR_ARB_HOLD_EN
    localparam int CW = rr_w(MAX_HOLD + 1);
    logic [CW-1:0] hold_q, nxt_hold;
`endif

    always_comb begin
        nxt_state = state_q;
        nxt_grant = '0;
        nxt_id    = '0;
        nxt_ptr   = ptr_q;
        keep      = 1'b0;
`ifdef RR_ARB_HOLD_EN
        nxt_hold  = '0;
        keep      = (state_q == BUSY) && bus.req[id_q] && (hold_q < CW'(MAX_HOLD));
`endif
        if (keep) begin
            nxt_grant = grant_q;
            nxt_id    = id_q;
`ifdef RR_ARB_HOLD_EN
            nxt_hold  = hold_q + CW'(1);
`endif
        end else if (pick_found) begin
            nxt_grant = pick_onehot;
            nxt_id    = pick_idx;
            nxt_ptr   = pick_idx;
`ifdef RR_ARB_HOLD_EN
            nxt_hold  = CW'(1);
`endif
        end
        nxt_state = (|bus.req) ? BUSY : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= W'(N - 1);
        end else begin
            state_q <= nxt_state;
            grant_q <= nxt_grant;
            id_q    <= nxt_id;
            valid_q <= |nxt_grant;
            ptr_q   <= nxt_ptr;
        end
    end

`ifdef RR_ARB_HOLD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= nxt_hold;
    end
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_id    = id_q;
    assign state           = state_q;

endmodule
